// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I-subset core: sequences the shared ALU,
// unified memory port, IR and register file, with a mem_ready stall handshake.
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       halted,
  output logic [3:0] state
);

  // Handshake: a memory access (fetch, load or store) is held in its state
  // until mem_ready is high; the transfer completes in that same cycle.

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state_q, state_d;
  logic   pc_update, branch;
  logic   ir_write_raw, mem_write_raw, reg_write_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        state_d      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        // Write strobe stays up through the cycle in which memory accepts it.
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Reset forces FETCH, whose fetch enables would otherwise follow mem_ready.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_write_raw;
  assign mem_write = rst_n & mem_write_raw;
  assign reg_write = rst_n & reg_write_raw;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: two instances (halt and drop on
// illegal op) against a cycle model, with per-cycle expected output vectors.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] ILL = 7'b1111111;

  logic       clk, rst_n, zero, mem_ready;
  logic [6:0] op;
  logic       pcw0, adr0, mw0, irw0, rw0, h0;
  logic [1:0] rs0, asa0, asb0, aop0, imm0;
  logic [3:0] st0;
  logic       pcw1, adr1, mw1, irw1, rw1, h1;
  logic [1:0] rs1, asa1, asb1, aop1, imm1;
  logic [3:0] st1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  string phase = "reset";
  logic [3:0]  ms0, ms1;
  logic [19:0] exp_q[$];
  logic [19:0] obs0, obs1;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw0), .adr_src(adr0), .mem_write(mw0), .ir_write(irw0),
    .result_src(rs0), .alu_src_a(asa0), .alu_src_b(asb0), .alu_op(aop0),
    .imm_src(imm0), .reg_write(rw0), .halted(h0), .state(st0));

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_drop (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw1), .adr_src(adr1), .mem_write(mw1), .ir_write(irw1),
    .result_src(rs1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1),
    .imm_src(imm1), .reg_write(rw1), .halted(h1), .state(st1));

  assign obs0 = {st0, pcw0, adr0, mw0, irw0, rs0, asa0, asb0, aop0, imm0, rw0, h0};
  assign obs1 = {st1, pcw1, adr1, mw1, irw1, rs1, asa1, asb1, aop1, imm1, rw1, h1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected output vector, same field order as obs0/obs1.
  function automatic logic [19:0] model_out(input logic [3:0] s, input logic [6:0] o,
                                            input logic z, input logic mr, input logic rn);
    logic pcw, adr, mw, irw, rw, hlt;
    logic [1:0] rs, asa, asb, aop, imm;
    {pcw, adr, mw, irw, rw, hlt} = '0;
    {rs, asa, asb, aop} = '0;
    case (o)
      SW:      imm = 2'b01;
      BEQ:     imm = 2'b10;
      JAL:     imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (s)
      4'd0:  begin asb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      4'd1:  begin asa = 2'b01; asb = 2'b01; end
      4'd2:  begin asa = 2'b10; asb = 2'b01; end
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'b01; rw = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; end
      4'd6:  begin asa = 2'b10; aop = 2'b10; end
      4'd7:  rw = 1'b1;
      4'd8:  begin asa = 2'b10; asb = 2'b01; aop = 2'b10; end
      4'd9:  begin asa = 2'b01; asb = 2'b10; pcw = 1'b1; end
      4'd10: begin asa = 2'b10; aop = 2'b01; pcw = z; end
      4'd11: hlt = 1'b1;
      default: ;
    endcase
    if (!rn) begin pcw = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; end
    return {s, pcw, adr, mw, irw, rs, asa, asb, aop, imm, rw, hlt};
  endfunction

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic [6:0] o,
                                            input logic mr, input logic halt_mode);
    case (s)
      4'd0: return mr ? 4'd1 : 4'd0;
      4'd1: begin
        if (o == LW || o == SW) return 4'd2;
        if (o == RT)  return 4'd6;
        if (o == IT)  return 4'd8;
        if (o == JAL) return 4'd9;
        if (o == BEQ) return 4'd10;
        return halt_mode ? 4'd11 : 4'd0;
      end
      4'd2:  return (o == LW) ? 4'd3 : 4'd5;
      4'd3:  return mr ? 4'd4 : 4'd3;
      4'd5:  return mr ? 4'd0 : 4'd5;
      4'd6, 4'd8, 4'd9: return 4'd7;
      4'd11: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  // One clock: drive, queue expectations, compare mid-cycle, advance models.
  task automatic cycle(input logic [6:0] o, input logic z, input logic m);
    op = o; zero = z; mem_ready = m;
    if (!rst_n) begin ms0 = 4'd0; ms1 = 4'd0; end
    exp_q.push_back(model_out(ms0, o, z, m, rst_n));
    exp_q.push_back(model_out(ms1, o, z, m, rst_n));
    #3;
    check($sformatf("%s_halt_c%0d", phase, cyc), {12'd0, obs0}, {12'd0, exp_q.pop_front()});
    check($sformatf("%s_drop_c%0d", phase, cyc), {12'd0, obs1}, {12'd0, exp_q.pop_front()});
    @(posedge clk); #1;
    ms0 = rst_n ? model_next(ms0, o, m, 1'b1) : 4'd0;
    ms1 = rst_n ? model_next(ms1, o, m, 1'b0) : 4'd0;
    cyc++;
  endtask

  task automatic run(input logic [6:0] o, input logic z, input logic m, input int n);
    for (int i = 0; i < n; i++) cycle(o, z, m);
  endtask

  initial begin
    logic [6:0] ops [8];
    logic [6:0] cur_op;
    int halt_cnt;
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT;
    ops[4] = JAL; ops[5] = BEQ; ops[6] = ILL; ops[7] = 7'b0000000;
    rst_n = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;
    ms0 = 4'd0; ms1 = 4'd0;
    @(posedge clk); #1;
    run(LW, 1'b0, 1'b1, 2);
    rst_n = 1'b1;

    phase = "lw";       run(LW, 1'b0, 1'b1, 5);
    check("lw_back_to_fetch", {28'd0, st0}, 32'd0);
    phase = "beq_taken"; run(BEQ, 1'b1, 1'b1, 3);
    phase = "beq_not";   run(BEQ, 1'b0, 1'b1, 3);
    phase = "sw_stall";
    run(SW, 1'b0, 1'b1, 3);
    run(SW, 1'b0, 1'b0, 3);
    run(SW, 1'b0, 1'b1, 1);
    check("sw_left_memwrite", {28'd0, st0}, 32'd0);
    phase = "fetch_stall";
    run(RT, 1'b0, 1'b0, 2);
    run(RT, 1'b0, 1'b1, 4);
    phase = "itype"; run(IT, 1'b0, 1'b1, 4);
    phase = "jal";   run(JAL, 1'b1, 1'b1, 4);
    phase = "illegal"; run(ILL, 1'b0, 1'b1, 12);
    check("illegal_halted", {31'd0, h0}, 32'd1);

    // Reset while the halt instance is HALTed and the drop instance loops fetch/decode.
    phase = "halt_reset";
    rst_n = 1'b0; run(LW, 1'b0, 1'b1, 1);
    rst_n = 1'b1;

    // lw up to MEMWB, then pull reset mid-cycle.
    phase = "lw_to_memwb"; run(LW, 1'b0, 1'b1, 4);
    check("in_memwb", {28'd0, st0}, 32'd4);
    phase = "mid_reset";
    rst_n = 1'b0;
    #1;
    check("async_state", {28'd0, st0}, 32'd0);
    check("async_reg_write", {31'd0, rw0}, 32'd0);
    run(RT, 1'b0, 1'b1, 2);
    rst_n = 1'b1;
    phase = "rtype_after_reset"; run(RT, 1'b0, 1'b1, 5);

    phase = "random";
    cur_op = LW;
    halt_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (ms0 == 4'd0 && ms1 == 4'd0) cur_op = ops[$urandom_range(0, 7)];
      if (ms0 == 4'd11) halt_cnt++;
      if (halt_cnt > 3) begin
        rst_n = 1'b0; halt_cnt = 0;
      end else begin
        rst_n = 1'b1;
      end
      cycle(cur_op, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    rst_n = 1'b1;

    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
